// File: rtl/alarm_ctrl_multi.sv
// alarm_ctrl_multi
//   Mode/edit controller for NUM_ALARMS independent alarms. Owns the alarm
//   registers, per-alarm arm flags and snooze counters, and drives the time
//   counter (run/adjust) and the display mux.
// Ports
//   clk, rst (async, active-low)
//   tick_1hz, minute_tick         : one-cycle timing pulses
//   cur_hour, cur_min             : current time of day
//   btn_c/u/d/l/r                 : debounced one-cycle button pulses
//   time_run, time_adj            : time counter enable / {inc_h,dec_h,inc_m,dec_m}
//   disp_alarm, sel_idx           : display source and selected alarm
//   alm_hour, alm_min             : alarm sel_idx contents
//   armed, buzzer, ring_idx       : arm flags, tone enable, ringing alarm
//   mode_led                      : one-hot {RING,SET_AM,SET_AH,SET_TM,SET_TH,RUN}
module alarm_ctrl_multi #(
   parameter int NUM_ALARMS     = 2,
   parameter int IDX_W          = 1,
   parameter int SNOOZE_MIN     = 5,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick_1hz,
   input  logic                  minute_tick,
   input  logic [4:0]            cur_hour,
   input  logic [5:0]            cur_min,
   input  logic                  btn_c,
   input  logic                  btn_u,
   input  logic                  btn_d,
   input  logic                  btn_l,
   input  logic                  btn_r,
   output logic                  time_run,
   output logic [3:0]            time_adj,
   output logic                  disp_alarm,
   output logic [IDX_W-1:0]      sel_idx,
   output logic [4:0]            alm_hour,
   output logic [5:0]            alm_min,
   output logic [NUM_ALARMS-1:0] armed,
   output logic                  buzzer,
   output logic [IDX_W-1:0]      ring_idx,
   output logic [5:0]            mode_led
);

   typedef enum logic [2:0] {S_RUN, S_TH, S_TM, S_AH, S_AM, S_RING} state_t;

   state_t                state, state_n;
   logic [IDX_W-1:0]      sel_n, ring_idx_n, fire_idx;
   logic [4:0]            alm_h   [NUM_ALARMS];
   logic [4:0]            alm_h_n [NUM_ALARMS];
   logic [5:0]            alm_m   [NUM_ALARMS];
   logic [5:0]            alm_m_n [NUM_ALARMS];
   logic [5:0]            snz_cnt   [NUM_ALARMS];
   logic [5:0]            snz_cnt_n [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] armed_n, snz_pend, snz_pend_n, snz_exp;
   logic [7:0]            ring_cnt, ring_cnt_n;
   logic [3:0]            adj_n;
   logic                  buzzer_n, fired;
   logic                  w_c, w_r, w_l, w_u, w_d;

   function automatic logic [5:0] led_of(input state_t s);
      case (s)
         S_RUN:   return 6'b000001;
         S_TH:    return 6'b000010;
         S_TM:    return 6'b000100;
         S_AH:    return 6'b001000;
         S_AM:    return 6'b010000;
         S_RING:  return 6'b100000;
         default: return 6'b000001;
      endcase
   endfunction

   // Only the highest-priority button acts: c > r > l > u > d.
   assign w_c = btn_c;
   assign w_r = btn_r & ~btn_c;
   assign w_l = btn_l & ~btn_c & ~btn_r;
   assign w_u = btn_u & ~btn_c & ~btn_r & ~btn_l;
   assign w_d = btn_d & ~btn_c & ~btn_r & ~btn_l & ~btn_u;

   always_comb begin
      state_n    = state;
      sel_n      = sel_idx;
      ring_idx_n = ring_idx;
      alm_h_n    = alm_h;
      alm_m_n    = alm_m;
      armed_n    = armed;
      snz_pend_n = snz_pend;
      snz_cnt_n  = snz_cnt;
      snz_exp    = '0;
      buzzer_n   = buzzer;
      adj_n      = 4'b0000;
      ring_cnt_n = ring_cnt;
      fired      = 1'b0;
      fire_idx   = '0;

      // Snooze countdown runs in every state; an expiring counter frees its
      // slot even when the trigger itself is ignored (SET states, RING).
      for (int k = 0; k < NUM_ALARMS; k++) begin
         if (minute_tick && snz_pend[k]) begin
            snz_cnt_n[k] = snz_cnt[k] - 6'd1;
            if (snz_cnt[k] <= 6'd1) begin
               snz_exp[k]    = 1'b1;
               snz_pend_n[k] = 1'b0;
            end
         end
      end

      // Descending scan so the lowest firing index is the one kept.
      for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
         if (minute_tick && ((armed[k] && cur_hour == alm_h[k] && cur_min == alm_m[k])
                             || snz_exp[k])) begin
            fired    = 1'b1;
            fire_idx = IDX_W'(k);
         end
      end

      case (state)
         S_RUN: begin
            if (fired) begin
               state_n    = S_RING;
               ring_idx_n = fire_idx;
               buzzer_n   = 1'b1;
               ring_cnt_n = 8'd0;
            end else if (w_c) begin
               state_n = S_TH;
            end else if (w_r) begin
               sel_n = (sel_idx == IDX_W'(NUM_ALARMS - 1)) ? '0 : sel_idx + IDX_W'(1);
            end else if (w_l) begin
               sel_n = (sel_idx == '0) ? IDX_W'(NUM_ALARMS - 1) : sel_idx - IDX_W'(1);
            end else if (w_u) begin
               armed_n[sel_idx] = ~armed[sel_idx];
               if (armed[sel_idx]) snz_pend_n[sel_idx] = 1'b0;
            end
         end
         S_TH: begin
            if (w_c)      state_n = S_RUN;
            else if (w_r) state_n = S_TM;
            else if (w_l) state_n = S_AM;
            else if (w_u) adj_n   = 4'b1000;
            else if (w_d) adj_n   = 4'b0100;
         end
         S_TM: begin
            if (w_c)      state_n = S_RUN;
            else if (w_r) state_n = S_AH;
            else if (w_l) state_n = S_TH;
            else if (w_u) adj_n   = 4'b0010;
            else if (w_d) adj_n   = 4'b0001;
         end
         S_AH: begin
            if (w_c)      state_n = S_RUN;
            else if (w_r) state_n = S_AM;
            else if (w_l) state_n = S_TM;
            else if (w_u) begin
               alm_h_n[sel_idx]    = (alm_h[sel_idx] == 5'd23) ? 5'd0 : alm_h[sel_idx] + 5'd1;
               snz_pend_n[sel_idx] = 1'b0;
            end else if (w_d) begin
               alm_h_n[sel_idx]    = (alm_h[sel_idx] == 5'd0) ? 5'd23 : alm_h[sel_idx] - 5'd1;
               snz_pend_n[sel_idx] = 1'b0;
            end
         end
         S_AM: begin
            if (w_c)      state_n = S_RUN;
            else if (w_r) state_n = S_TH;
            else if (w_l) state_n = S_AH;
            else if (w_u) begin
               alm_m_n[sel_idx]    = (alm_m[sel_idx] == 6'd59) ? 6'd0 : alm_m[sel_idx] + 6'd1;
               snz_pend_n[sel_idx] = 1'b0;
            end else if (w_d) begin
               alm_m_n[sel_idx]    = (alm_m[sel_idx] == 6'd0) ? 6'd59 : alm_m[sel_idx] - 6'd1;
               snz_pend_n[sel_idx] = 1'b0;
            end
         end
         S_RING: begin
            if (w_c) begin
               state_n              = S_RUN;
               snz_pend_n[ring_idx] = 1'b0;
            end else if (w_r || w_l || w_u || w_d) begin
               state_n              = S_RUN;
               snz_pend_n[ring_idx] = 1'b1;
               snz_cnt_n[ring_idx]  = 6'(SNOOZE_MIN);
            end else if (tick_1hz) begin
               buzzer_n   = ~buzzer;
               ring_cnt_n = ring_cnt + 8'd1;
               if ({1'b0, ring_cnt} + 9'd1 == 9'(RING_TIMEOUT_S)) state_n = S_RUN;
            end
         end
         default: state_n = S_RUN;
      endcase

      if (state_n != S_RING) buzzer_n = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_RUN;
         sel_idx    <= '0;
         ring_idx   <= '0;
         armed      <= '0;
         snz_pend   <= '0;
         ring_cnt   <= 8'd0;
         buzzer     <= 1'b0;
         time_adj   <= 4'b0000;
         time_run   <= 1'b1;
         disp_alarm <= 1'b0;
         mode_led   <= 6'b000001;
         alm_hour   <= 5'd0;
         alm_min    <= 6'd0;
         for (int k = 0; k < NUM_ALARMS; k++) begin
            alm_h[k]   <= 5'd0;
            alm_m[k]   <= 6'd0;
            snz_cnt[k] <= 6'd0;
         end
      end else begin
         state      <= state_n;
         sel_idx    <= sel_n;
         ring_idx   <= ring_idx_n;
         armed      <= armed_n;
         snz_pend   <= snz_pend_n;
         ring_cnt   <= ring_cnt_n;
         buzzer     <= buzzer_n;
         time_adj   <= adj_n;
         time_run   <= (state_n == S_RUN) || (state_n == S_RING);
         disp_alarm <= (state_n == S_AH) || (state_n == S_AM);
         mode_led   <= led_of(state_n);
         alm_hour   <= alm_h_n[sel_n];
         alm_min    <= alm_m_n[sel_n];
         alm_h      <= alm_h_n;
         alm_m      <= alm_m_n;
         snz_cnt    <= snz_cnt_n;
      end
   end

endmodule
